// File: rtl/mux2_64bit_arbiter_pkg.sv
// Shared definitions for the two-requester 64-bit arbiter.
// Holds the default data/counter widths, the source index constants
// and the round-robin grant helper used by the arbiter top.
package mux2_64bit_arbiter_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = 16;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Round-robin pick: a tie goes to the requester that did not win last,
  // a lone requester always wins, and an idle cycle keeps the old pointer.
  function automatic logic pick_grant(input logic last, input logic v0, input logic v1);
    logic g;
    if (v0 && v1) begin
      g = ~last;
    end else if (v0) begin
      g = SRC0;
    end else if (v1) begin
      g = SRC1;
    end else begin
      g = last;
    end
    return g;
  endfunction

endpackage

// File: rtl/mux2_64bit_arbiter_if.sv
// Bus bundle between two valid/ready producers, the arbiter and one consumer.
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding environment (producers + consumer).
//   w0_valid/w0/w0_ready : requester 0 handshake and data
//   w1_valid/w1/w1_ready : requester 1 handshake and data
//   f_valid/f/f_src/f_ready : output stage toward the consumer
//   s : mux select currently applied
//   gnt_cnt0/gnt_cnt1 : accepted-word counters per requester
interface mux2_64bit_arbiter_if
  import mux2_64bit_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             w0_valid;
  logic [WIDTH-1:0] w0;
  logic             w0_ready;
  logic             w1_valid;
  logic [WIDTH-1:0] w1;
  logic             w1_ready;
  logic             f_valid;
  logic [WIDTH-1:0] f;
  logic             f_src;
  logic             f_ready;
  logic             s;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  modport slave (
    input  w0_valid, w0, w1_valid, w1, f_ready,
    output w0_ready, w1_ready, f_valid, f, f_src, s, gnt_cnt0, gnt_cnt1
  );

  modport master (
    output w0_valid, w0, w1_valid, w1, f_ready,
    input  w0_ready, w1_ready, f_valid, f, f_src, s, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/mux2_64bit_arbiter_mux.sv
// 2:1 datapath mux shared by the two requesters.
//   w0, w1 : candidate words
//   s      : select, 0 picks w0, 1 picks w1
//   f      : selected word
module mux2_64bit
  import mux2_64bit_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic             s,
  output logic [WIDTH-1:0] f
);

  // Select the word named by s.
  always_comb begin
    f = w0;
    case (s)
      SRC0:    f = w0;
      SRC1:    f = w1;
      default: f = w0;
    endcase
  end

endmodule

// File: rtl/mux2_64bit_arbiter.sv
// Round-robin arbiter sharing one 2:1 64-bit mux between two requesters,
// feeding a one-entry registered output stage and counting grants.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester/consumer bundle (slave view), see mux2_64bit_arbiter_if
module mux2_64bit_arbiter
  import mux2_64bit_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux2_64bit_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             last_r;
  logic             f_valid_r;
  logic [WIDTH-1:0] f_r;
  logic             f_src_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic             load_ok_s;
  logic             grant_s;
  logic             w0_ready_s;
  logic             w1_ready_s;
  logic             take_s;
  logic [WIDTH-1:0] mux_f_s;

  // The stage may refill in the same cycle it drains.
  assign load_ok_s = !f_valid_r || bus.f_ready;
  assign grant_s   = pick_grant(last_r, bus.w0_valid, bus.w1_valid);

  // rst_n gates the readies so nothing looks accepted while in reset.
  assign w0_ready_s = rst_n && load_ok_s && bus.w0_valid && (grant_s == SRC0);
  assign w1_ready_s = rst_n && load_ok_s && bus.w1_valid && (grant_s == SRC1);
  assign take_s     = w0_ready_s || w1_ready_s;

  mux2_64bit #(.WIDTH(WIDTH)) u_mux (
    .w0 (bus.w0),
    .w1 (bus.w1),
    .s  (grant_s),
    .f  (mux_f_s)
  );

  // Output stage, round-robin pointer and grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid_r <= 1'b0;
      f_r       <= '0;
      f_src_r   <= SRC0;
      last_r    <= SRC1;
      cnt0_r    <= '0;
      cnt1_r    <= '0;
    end else if (take_s) begin
      f_valid_r <= 1'b1;
      f_r       <= mux_f_s;
      f_src_r   <= grant_s;
      last_r    <= grant_s;
      if (grant_s == SRC0) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end else begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end else if (load_ok_s) begin
      // Drained with nothing to replace it; data and source are kept.
      f_valid_r <= 1'b0;
    end else begin
      f_valid_r <= f_valid_r;
    end
  end

  assign bus.w0_ready = w0_ready_s;
  assign bus.w1_ready = w1_ready_s;
  assign bus.f_valid  = f_valid_r;
  assign bus.f        = f_r;
  assign bus.f_src    = f_src_r;
  assign bus.s        = grant_s;
  assign bus.gnt_cnt0 = cnt0_r;
  assign bus.gnt_cnt1 = cnt1_r;

endmodule

// File: tb/tb_mux2_64bit_arbiter.sv
module tb_mux2_64bit_arbiter;

  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] D5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] DS = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DE = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mux2_64bit_arbiter_if #(.WIDTH(64), .CNT_W(16)) bus ();

  mux2_64bit_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        fr;
    logic [63:0] w0;
    logic [63:0] w1;
    logic        r0;
    logic        r1;
    logic        s;
    logic        fv;
    logic [63:0] f;
    logic        src;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs already driven; check handshake outputs, clock once, check state.
  task automatic step(input logic er0, input logic er1, input logic es, input logic efv,
                      input logic [63:0] ef, input logic esrc,
                      input logic [15:0] ec0, input logic [15:0] ec1, input string tag);
    #1;
    chk({tag, ".w0_ready"}, 64'(bus.w0_ready), 64'(er0));
    chk({tag, ".w1_ready"}, 64'(bus.w1_ready), 64'(er1));
    chk({tag, ".s"},        64'(bus.s),        64'(es));
    @(posedge clk);
    #1;
    chk({tag, ".f_valid"},  64'(bus.f_valid),  64'(efv));
    chk({tag, ".f"},        bus.f,             ef);
    chk({tag, ".f_src"},    64'(bus.f_src),    64'(esrc));
    chk({tag, ".gnt_cnt0"}, 64'(bus.gnt_cnt0), 64'(ec0));
    chk({tag, ".gnt_cnt1"}, 64'(bus.gnt_cnt1), 64'(ec1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model state: who won most recently, what sits in the stage.
  int          m_last;
  bit          m_fv;
  logic [63:0] m_f;
  int          m_src;
  int          m_c0;
  int          m_c1;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.w0_valid = 1'b1;
    bus.w1_valid = 1'b1;
    bus.w0 = DA;
    bus.w1 = D5;
    bus.f_ready = 1'b1;

    // Reset held with both requesters asking.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.w0_ready", 64'(bus.w0_ready), 64'd0);
    chk("rst.w1_ready", 64'(bus.w1_ready), 64'd0);
    chk("rst.f_valid",  64'(bus.f_valid),  64'd0);
    chk("rst.f",        bus.f,             64'd0);
    chk("rst.gnt_cnt0", 64'(bus.gnt_cnt0), 64'd0);
    chk("rst.gnt_cnt1", 64'(bus.gnt_cnt1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          rst   v0    v1    fr    w0  w1  r0    r1    s     fv    f   src   c0      c1
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, DS, D5, 1'b1, 1'b0, 1'b0, 1'b1, DS, 1'b0, 16'd1, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, DA, D5, 1'b1, 1'b0, 1'b0, 1'b1, DA, 1'b0, 16'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, DA, D5, 1'b0, 1'b1, 1'b1, 1'b1, D5, 1'b1, 16'd1, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, DA, D5, 1'b1, 1'b0, 1'b0, 1'b1, DA, 1'b0, 16'd2, 16'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, DA, D5, 1'b0, 1'b1, 1'b1, 1'b1, D5, 1'b1, 16'd2, 16'd2};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, DA, D5, 1'b1, 1'b0, 1'b0, 1'b1, DA, 1'b0, 16'd3, 16'd2};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, DA, D5, 1'b0, 1'b0, 1'b1, 1'b1, DA, 1'b0, 16'd3, 16'd2};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, DA, D5, 1'b0, 1'b0, 1'b1, 1'b1, DA, 1'b0, 16'd3, 16'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, DA, D5, 1'b0, 1'b0, 1'b1, 1'b1, DA, 1'b0, 16'd3, 16'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, DA, D5, 1'b0, 1'b1, 1'b1, 1'b1, D5, 1'b1, 16'd3, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, DA, D5, 1'b0, 1'b0, 1'b1, 1'b0, D5, 1'b1, 16'd3, 16'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, DA, D5, 1'b0, 1'b0, 1'b1, 1'b0, D5, 1'b1, 16'd3, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, DA, DE, 1'b0, 1'b1, 1'b1, 1'b1, DE, 1'b1, 16'd3, 16'd4};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, DA, D5, 1'b0, 1'b0, 1'b0, 1'b1, DE, 1'b1, 16'd3, 16'd4};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      bus.w0_valid = tbl[i].v0;
      bus.w1_valid = tbl[i].v1;
      bus.f_ready  = tbl[i].fr;
      bus.w0       = tbl[i].w0;
      bus.w1       = tbl[i].w1;
      step(tbl[i].r0, tbl[i].r1, tbl[i].s, tbl[i].fv, tbl[i].f, tbl[i].src,
           tbl[i].c0, tbl[i].c1, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of an alternating stream.
    do_reset();
    bus.w0_valid = 1'b1;
    bus.w1_valid = 1'b1;
    bus.f_ready  = 1'b1;
    bus.w0 = DA;
    bus.w1 = D5;
    step(1'b1, 1'b0, 1'b0, 1'b1, DA, 1'b0, 16'd1, 16'd0, "mid.a");
    step(1'b0, 1'b1, 1'b1, 1'b1, D5, 1'b1, 16'd1, 16'd1, "mid.b");
    rst_n = 1'b0;
    #1;
    chk("mid.rst.f_valid",  64'(bus.f_valid),  64'd0);
    chk("mid.rst.gnt_cnt0", 64'(bus.gnt_cnt0), 64'd0);
    chk("mid.rst.gnt_cnt1", 64'(bus.gnt_cnt1), 64'd0);
    chk("mid.rst.w0_ready", 64'(bus.w0_ready), 64'd0);
    chk("mid.rst.w1_ready", 64'(bus.w1_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, DA, 1'b0, 16'd1, 16'd0, "mid.after");

    // Randomized traffic against the behavioural model.
    do_reset();
    m_last = 1;
    m_fv   = 1'b0;
    m_f    = 64'd0;
    m_src  = 0;
    m_c0   = 0;
    m_c1   = 0;
    for (int n = 0; n < 600; n++) begin
      bit v0, v1, fr, can_load;
      int win;
      logic [63:0] d0, d1;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 2) != 0);
      d0 = {$urandom(), $urandom()};
      d1 = {$urandom(), $urandom()};
      bus.w0_valid = v0;
      bus.w1_valid = v1;
      bus.f_ready  = fr;
      bus.w0 = d0;
      bus.w1 = d1;

      can_load = !m_fv || fr;
      if (v0 && v1)  win = 1 - m_last;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      else           win = -1;

      if (can_load && win >= 0) begin
        step(win == 0, win == 1, win[0], 1'b1, (win == 0) ? d0 : d1, win[0],
             16'((win == 0) ? m_c0 + 1 : m_c0), 16'((win == 1) ? m_c1 + 1 : m_c1),
             $sformatf("rnd%0d", n));
        m_fv   = 1'b1;
        m_f    = (win == 0) ? d0 : d1;
        m_src  = win;
        m_last = win;
        if (win == 0) m_c0 = (m_c0 + 1) % 65536;
        else          m_c1 = (m_c1 + 1) % 65536;
      end else begin
        if (can_load) m_fv = 1'b0;
        step(1'b0, 1'b0, (win < 0) ? m_last[0] : win[0], m_fv, m_f, m_src[0],
             16'(m_c0), 16'(m_c1), $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux2_64bit_arbiter.md
Name: mux2_64bit_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit 2:1 mux datapath between two valid/ready requesters.
- Registers the winner's word into a single output stage and drives a valid/ready consumer.
- The output stage is a one-entry buffer.
- Sits between two producer blocks and a single downstream consumer, and owns the mux select line.

Parameters:
- WIDTH, 64, data width of every data port.
- CNT_W, 16, width of the per-source grant counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- w0_valid  input  1  requester 0 holds a word.
- w0  input  WIDTH  requester 0 data.
- w0_ready  output  1  requester 0 word accepted this cycle.
- w1_valid  input  1  requester 1 holds a word.
- w1  input  WIDTH  requester 1 data.
- w1_ready  output  1  requester 1 word accepted this cycle.
- f_valid  output  1  output stage holds a word.
- f  output  WIDTH  output word.
- f_src  output  1  source index of the current output word.
- f_ready  input  1  consumer accepts f this cycle.
- s  output  1  mux select currently applied; 0 selects w0, 1 selects w1.
- gnt_cnt0  output  CNT_W  count of words accepted from requester 0.
- gnt_cnt1  output  CNT_W  count of words accepted from requester 1.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - f_valid=0, f=0, f_src=0.
  - last=1, so requester 0 wins the first tie.
  - gnt_cnt0=0, gnt_cnt1=0.
  - w0_ready=0 and w1_ready=0 combinationally while rst_n=0.
- Load condition: load_ok = !f_valid || f_ready. This is combinational; a full stage can refill in the same cycle it drains.
- Grant, combinational:
  - Both requesters valid: grant = ~last.
  - Only one valid: grant = that index.
  - Neither valid: grant = last.
- Select: s = grant, fed to the mux sub-module.
- Ready: wN_ready = load_ok && wN_valid && (grant==N). At most one ready is high in any cycle. Ready may depend on valid; producers must not make valid depend on ready.
- On acceptance (the rising clk where wN_ready=1):
  - f <= mux output, f_src <= N, f_valid <= 1.
  - last <= N.
  - gnt_cntN <= gnt_cntN + 1, wrapping modulo 2^CNT_W with no saturation.
- If load_ok and no requester is valid: f_valid <= 0. f and f_src hold their last value.
- Stall: while f_valid && !f_ready, f, f_src, f_valid and last are frozen, and both readies are 0.
- Latency: one cycle from acceptance to f_valid. Full throughput is one word per cycle when f_ready is held high.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1,... No requester waits more than one accepted word.
- Reset mid-transfer: the buffered word is discarded and counters clear. After reset release, the first tie goes to requester 0.
- Held request: a requester that keeps valid high with changing data has no defined capture point until its ready is high. Only the value present at the accepting edge is transferred.

Decomposition:
- Shared include file mux2_64bit_defs.vh holds:
  - WIDTH default (64).
  - Source index constants SRC0=1'b0 and SRC1=1'b1.
- Sub-module: existing mux2_64bit (ports w0, w1, s, f), instantiated once for the datapath select.
- The arbiter contains only the grant logic, the output register and the counters.

Test Plan:
- Reset: hold rst_n=0 with w0_valid=w1_valid=1 -> w0_ready=w1_ready=0, f_valid=0, f=0, gnt_cnt0=gnt_cnt1=0.
- Single source: w0_valid=1, w0=64'h0123_4567_89AB_CDEF, f_ready=1 -> w0_ready=1 same cycle; next cycle f_valid=1, f=64'h0123_4567_89AB_CDEF, f_src=0; gnt_cnt0=1.
- Tie after reset, then alternation: w0=64'hAAAA..., w1=64'h5555..., both valid, f_ready=1 for 4 cycles -> f_src sequence 0,1,0,1; gnt_cnt0=2, gnt_cnt1=2.
- Backpressure: f holds 64'hAAAA...; drop f_ready for 3 cycles with both valid -> f, f_src and f_valid stable; both readies 0. Raise f_ready -> w1 accepted in that same cycle; f=64'h5555... one cycle later.
- Drain: one word is in f, no requester is valid, f_ready=1 -> f_valid=0 next cycle; f keeps its old value.
- Async reset mid-stream: pulse rst_n low between clk edges during alternation -> f_valid=0 and counters=0 immediately. The first tie after release grants requester 0.
